// File: rtl/encoder_struct_seq_pkg.sv
// encoder_struct_seq_pkg: shared width default and queue-occupancy states for encoder_struct_seq
package encoder_struct_seq_pkg;
  localparam int ENC_N_IN = 4;
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/encoder_struct_seq_prio_enc_comb.sv
// prio_enc_comb: combinational priority encoder, highest set bit wins, none flags an all-zero vector
module prio_enc_comb #(
  parameter int N_IN = 4,
  localparam int OUT_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req_i,
  output logic             none_o,
  output logic [OUT_W-1:0] idx_o
);
  // scan upward so a higher set bit overwrites any lower one
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_IN; i++) idx_o = req_i[i] ? i[OUT_W-1:0] : idx_o;
  end
  assign none_o = ~|req_i;
endmodule

// File: rtl/encoder_struct_seq.sv
// encoder_struct_seq: registered priority encoder behind a valid/ready handshake with a 2-entry output queue.
// Optional ENCODER_ONEHOT_CHECK_EN adds a per-entry err bit (more than one request bit set) on out_err.
module encoder_struct_seq
  import encoder_struct_seq_pkg::*;
#(
  parameter int N_IN = ENC_N_IN,
  localparam int OUT_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_none,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ENCODER_ONEHOT_CHECK_EN
  ,
  output logic             out_err
`endif
);
  typedef struct packed {
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic             err;
`endif
    logic             none;
    logic [OUT_W-1:0] idx;
  } entry_t;

  entry_t enc, head_q, head_d, tail_q, tail_d;
  state_e state_q, state_d;
  logic rdy_q, push, pop;

  prio_enc_comb #(.N_IN(N_IN)) u_enc (
    .req_i (in),
    .none_o(enc.none),
    .idx_o (enc.idx)
  );

`ifdef ENCODER_ONEHOT_CHECK_EN
  assign enc.err = $countones(in) > 1;
  assign out_err = head_q.err;
`endif

  assign in_ready  = rdy_q & (state_q != S_TWO);
  assign out_valid = state_q != S_EMPTY;
  assign out       = head_q.idx;
  assign out_none  = head_q.none;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // occupancy transitions; head always feeds the outputs, tail only fills from ONE
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: begin
        state_d = push ? S_ONE : S_EMPTY;
        head_d  = push ? enc : head_q;
      end
      S_ONE: begin
        state_d = (push & ~pop) ? S_TWO : (pop & ~push) ? S_EMPTY : S_ONE;
        head_d  = (push & pop) ? enc : head_q;
        tail_d  = (push & ~pop) ? enc : tail_q;
      end
      S_TWO: begin
        state_d = pop ? S_ONE : S_TWO;
        head_d  = pop ? tail_q : head_q;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // state and entry registers; rdy_q holds in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_encoder_struct_seq.sv
// tb_encoder_struct_seq: directed and random checks of encoder_struct_seq against a queue-based reference model
module tb_encoder_struct_seq;
  import encoder_struct_seq_pkg::*;
  localparam int W = ENC_N_IN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_none, out_valid;
  logic [$clog2(W)-1:0] out;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic out_err;
`endif

  int total = 0, bad = 0;
  logic [W-1:0] q[$];
  bit m_rdy = 0;

  encoder_struct_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_none (out_none),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    .out_err  (out_err)
`endif
  );

  always #5 clk = ~clk;

  // highest set bit of v, from the bit length of v
  function automatic int m_idx(logic [W-1:0] v);
    return (v == 0) ? 0 : $clog2(int'(v) + 1) - 1;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".valid"}, int'(out_valid), int'(q.size() != 0));
    chk({tag, ".ready"}, int'(in_ready), int'(m_rdy && q.size() < 2));
    if (q.size() != 0) begin
      chk({tag, ".out"}, int'(out), m_idx(q[0]));
      chk({tag, ".none"}, int'(out_none), int'(q[0] == 0));
`ifdef ENCODER_ONEHOT_CHECK_EN
      chk({tag, ".err"}, int'(out_err), int'($countones(q[0]) > 1));
`endif
    end
  endtask

  // one clock: drive, let the edge happen, update the model, sample 1 time unit later
  task automatic cyc(string tag, logic [W-1:0] v, logic vld, logic ordy);
    bit push, pop;
    din = v;
    in_valid = vld;
    out_ready = ordy;
    push = vld && m_rdy && q.size() < 2;
    pop = q.size() != 0 && ordy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(v);
    m_rdy = 1;
    #1;
    check_outs(tag);
  endtask

  initial begin
    #2;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.out", int'(out), 0);
    chk("rst.none", int'(out_none), 0);
    chk("rst.ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel.ready", int'(in_ready), 0);
    cyc("idle", '0, 1'b0, 1'b0);
    // test 1: single push then drain
    cyc("t1.push", 4'b0100, 1'b1, 1'b1);
    chk("t1.out2", int'(out), 2);
    cyc("t1.pop", 4'b0000, 1'b0, 1'b1);
    chk("t1.empty", int'(out_valid), 0);
    // test 2: fill to TWO, blocked push, then drain in order
    cyc("t2.p1", 4'b0001, 1'b1, 1'b0);
    cyc("t2.p2", 4'b1000, 1'b1, 1'b0);
    chk("t2.full", int'(in_ready), 0);
    cyc("t2.blk", 4'b0110, 1'b1, 1'b0);
    chk("t2.hold", int'(out), 0);
    cyc("t2.d1", 4'b0000, 1'b0, 1'b1);
    chk("t2.out3", int'(out), 3);
    cyc("t2.d2", 4'b0000, 1'b0, 1'b1);
    // test 3: push and pop on the same edge in ONE
    cyc("t3.p", 4'b1001, 1'b1, 1'b0);
    cyc("t3.pp", 4'b0010, 1'b1, 1'b1);
    chk("t3.out1", int'(out), 1);
    cyc("t3.d", 4'b0000, 1'b0, 1'b1);
    // test 4: zero vector, then all vectors with X when idle
    cyc("t4.zero", 4'b0000, 1'b1, 1'b1);
    chk("t4.none", int'(out_none), 1);
    for (int v = 0; v < (1 << W); v++) begin
      cyc("t4.ex", W'(v), 1'b1, 1'b1);
      cyc("t4.x", 'x, 1'b0, 1'b0);
    end
    cyc("t4.d", 4'b0000, 1'b0, 1'b1);
    // test 6 vectors (err only checked when the feature is built in)
    cyc("t6.a", 4'b1010, 1'b1, 1'b1);
    cyc("t6.b", 4'b1000, 1'b1, 1'b1);
    // random traffic
    for (int i = 0; i < 300; i++)
      cyc("rnd", W'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    // test 5: reset while holding two entries, asserted between edges
    cyc("t5.p1", 4'b0100, 1'b1, 1'b0);
    cyc("t5.p2", 4'b0011, 1'b1, 1'b0);
    chk("t5.full", int'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_rdy = 0;
    chk("t5.valid", int'(out_valid), 0);
    chk("t5.out", int'(out), 0);
    chk("t5.ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5.rel", int'(in_ready), 0);
    cyc("t5.edge", '0, 1'b0, 1'b0);
    chk("t5.rdy1", int'(in_ready), 1);
    cyc("t5.push", 4'b0111, 1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
